mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: instruction fetch (IF) and load/store (LS).
- Enables a unified instruction/data memory behind the RV32I core, replacing separate imem and data RAM.
- Supports a fixed memory read latency and allows one read in flight at a time.
- LS has default priority. A starvation counter guarantees IF forward progress.

Parameters:
RD_LATENCY, 1, cycles from memory enable to valid i_mem_rdata (legal 1..4)
STARVE_MAX, 4, consecutive denied IF cycles before IF is forced priority (legal 1..15)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_if_req  input  1  IF read request; held with address until granted
i_if_addr  input  32  IF word address
o_if_gnt  output  1  IF request accepted this cycle
o_if_rvalid  output  1  IF read data valid (1-cycle pulse)
o_if_rdata  output  32  IF read data; 0 when o_if_rvalid=0
i_ls_req  input  1  LS request; held with all fields until granted
i_ls_we  input  1  1=store, 0=load
i_ls_addr  input  32  LS address
i_ls_wdata  input  32  store data
i_ls_bmask  input  4  store byte enables
o_ls_gnt  output  1  LS request accepted this cycle
o_ls_rvalid  output  1  LS load data valid (1-cycle pulse)
o_ls_rdata  output  32  LS load data; 0 when o_ls_rvalid=0
o_mem_en  output  1  memory access strobe
o_mem_we  output  1  memory write enable
o_mem_addr  output  32  memory address
o_mem_wdata  output  32  memory write data
o_mem_bmask  output  4  memory byte enables
i_mem_rdata  input  32  memory read data
o_busy  output  1  read in flight (state != IDLE); core stalls on this

Behaviour:
- FSM states:
  - IDLE, RD_WAIT.
  - Registers: state, owner (IF/LS), lat_cnt (2 bits), starve_cnt (4 bits, saturating).
- Reset (i_rst=1 at an edge):
  - state=IDLE, lat_cnt=0, starve_cnt=0, owner=LS.
  - While i_rst is high, all outputs are forced 0, including combinational gnt/mem_* outputs.
  - No grant is issued during reset.
- Arbitration happens only in IDLE, combinationally in the same cycle:
  - force_if = (starve_cnt >= STARVE_MAX).
  - If i_ls_req && !(force_if && i_if_req): grant LS. Otherwise, if i_if_req: grant IF.
  - Exactly one gnt per cycle, at most.
- Granted cycle T:
  - o_mem_en=1. o_mem_addr is driven from the winner.
  - For an LS grant: o_mem_we=i_ls_we, o_mem_wdata=i_ls_wdata, o_mem_bmask=i_ls_bmask.
  - For an IF grant: we=0, bmask=4'b0000, wdata=0.
- When not granting: all mem_* outputs are 0.
- Store (LS, we=1):
  - Completes at T. State remains IDLE, so a new grant is possible at T+1.
  - No rvalid is issued for a store.
- Read (IF, or LS with we=0):
  - At the edge after T: state=RD_WAIT, owner=winner, lat_cnt=RD_LATENCY-1.
  - In RD_WAIT: lat_cnt decrements each cycle.
  - When lat_cnt==0: assert the owner's rvalid for that cycle (T+RD_LATENCY), rdata=i_mem_rdata, then return to IDLE.
  - Next grant no earlier than T+RD_LATENCY+1.
- o_busy = (state==RD_WAIT).
- Starvation counter:
  - Increments, saturating at 15, in each cycle where i_if_req=1 and o_if_gnt=0.
  - Clears to 0 on an IF grant or when i_if_req=0.
  - RD_WAIT cycles with IF pending also count.
- Requester rules:
  - Requesters hold req and payload stable until gnt.
  - A requester may present a new request in the cycle after gnt.
  - Dropping req before gnt is legal; the request is simply not served.
- Reset during RD_WAIT: the transaction is discarded, no rvalid is ever produced, and o_busy=0 at the first post-reset cycle.

Test Plan:
1. Reset with both reqs high for 3 cycles -> no gnt, o_mem_en=0. First cycle after release -> o_ls_gnt=1, o_if_gnt=0.
2. RD_LATENCY=2, IF read addr 0x100, memory returns 0x00500093 at T+2 -> o_if_gnt at T, o_busy at T+1..T+2, o_if_rvalid=1 with o_if_rdata=0x00500093 at T+2 only.
3. Simultaneous IF read 0x0 and LS load 0x2000 -> LS granted at T, o_ls_rvalid at T+RD_LATENCY. IF granted at T+RD_LATENCY+1. IF rdata never appears on LS port.
4. STARVE_MAX=4, LS issues stores every cycle, IF req held from cycle 0 -> IF denied cycles 0..3, o_if_gnt=1 in cycle 4, starve_cnt=0 after.
5. LS store addr 0x7000, wdata 0xDEADBEEF, bmask 4'b0011 -> same cycle o_mem_en=1, we=1, bmask=0011, data/addr passed through. No rvalid. A new IF grant is possible the next cycle.
6. RD_LATENCY=3, LS load granted at T, i_rst pulsed at T+1 -> no o_ls_rvalid at T+3. o_busy=0 and grants resume after reset release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous memory between
// instruction fetch (IF) and load/store (LS); LS wins unless IF is starving.
module mem_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam logic       ST_IDLE    = 1'b0;
  localparam logic       ST_RD_WAIT = 1'b1;
  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LS     = 1'b1;
  localparam logic [1:0] LAT_INIT   = 2'(RD_LATENCY - 1);
  localparam logic [3:0] STARVE_TH  = 4'(STARVE_MAX);

  logic       r_state;
  logic       r_owner;
  logic [1:0] r_lat_cnt;
  logic [3:0] r_starve_cnt;

  logic w_idle;
  logic w_force_if;
  logic w_ls_gnt;
  logic w_if_gnt;
  logic w_rd_grant;
  logic w_rd_done;

  // Arbitration is purely combinational and only legal while IDLE and out of reset.
  always_comb begin
    w_idle     = !i_rst && (r_state == ST_IDLE);
    w_force_if = (r_starve_cnt >= STARVE_TH);
    w_ls_gnt   = w_idle && i_ls_req && !(w_force_if && i_if_req);
    w_if_gnt   = w_idle && i_if_req && !w_ls_gnt;
    w_rd_grant = w_if_gnt || (w_ls_gnt && !i_ls_we);
    w_rd_done  = !i_rst && (r_state == ST_RD_WAIT) && (r_lat_cnt == 2'd0);
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    if (w_ls_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_bmask = i_ls_bmask;
    end else if (w_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
    end
  end

  // Read data is steered to the owner only in its single valid cycle.
  always_comb begin
    o_if_gnt    = w_if_gnt;
    o_ls_gnt    = w_ls_gnt;
    o_if_rvalid = w_rd_done && (r_owner == OWN_IF);
    o_ls_rvalid = w_rd_done && (r_owner == OWN_LS);
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'd0;
    o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : 32'd0;
    o_busy      = !i_rst && (r_state == ST_RD_WAIT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_LS;
      r_lat_cnt    <= 2'd0;
      r_starve_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_grant) begin
            r_state   <= ST_RD_WAIT;
            r_owner   <= w_ls_gnt ? OWN_LS : OWN_IF;
            r_lat_cnt <= LAT_INIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_lat_cnt == 2'd0) r_state <= ST_IDLE;
          else                   r_lat_cnt <= r_lat_cnt - 2'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Waiting cycles in RD_WAIT count toward starvation as well.
      if (i_if_req && !w_if_gnt) begin
        if (r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table with a memory model and a
// read-data scoreboard, plus reset-during-read sequence.
module tb_mem_arbiter;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_we;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_en, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LATENCY(RD_LAT), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: byte-masked writes, reads return data RD_LAT cycles after enable.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] dpipe [0:3];
  logic        vpipe [0:3];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  initial for (int k = 0; k < 4; k++) begin
    vpipe[k] = 1'b0;
    dpipe[k] = 32'd0;
  end

  always @(posedge clk) begin
    if (o_mem_en && o_mem_we) begin
      logic [31:0] w;
      w = mem_rd(o_mem_addr);
      for (int b = 0; b < 4; b++)
        if (o_mem_bmask[b]) w[b*8 +: 8] = o_mem_wdata[b*8 +: 8];
      mem[o_mem_addr] = w;
    end
    dpipe[0] <= mem_rd(o_mem_addr);
    vpipe[0] <= o_mem_en && !o_mem_we;
    for (int k = 1; k < 4; k++) begin
      dpipe[k] <= dpipe[k-1];
      vpipe[k] <= vpipe[k-1];
    end
  end

  assign i_mem_rdata = vpipe[RD_LAT-1] ? dpipe[RD_LAT-1] : 32'hA5A5_A5A5;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
    int          due;
  } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("missing_rvalid", 32'(sbq[0].due), 32'(cyc));
        void'(sbq.pop_front());
      end
      if (o_if_rvalid || o_ls_rvalid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, o_ls_rvalid, o_if_rvalid}, 32'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("if_rvalid", 32'(o_if_rvalid), 32'(!e.is_ls));
          chk("ls_rvalid", 32'(o_ls_rvalid), 32'(e.is_ls));
          chk("rdata", e.is_ls ? o_ls_rdata : o_if_rdata, e.data);
          chk("other_rdata_zero", e.is_ls ? o_if_rdata : o_ls_rdata, 32'd0);
          chk("rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("if_rdata_idle", o_if_rdata, 32'd0);
        chk("ls_rdata_idle", o_ls_rdata, 32'd0);
      end
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_bmask;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic        e_busy;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic lr, logic lw,
                              logic [31:0] la, logic [31:0] ld, logic [3:0] lb,
                              logic eig, logic elg, logic eb);
    vec_t v;
    v = '{ir, ia, lr, lw, la, ld, lb, eig, elg, eb};
    return v;
  endfunction

  task automatic run_row(input vec_t v, input logic rst, input bit track);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_bm;
    @(posedge clk);
    #1;
    i_rst      = rst;
    i_if_req   = v.if_req;
    i_if_addr  = v.if_addr;
    i_ls_req   = v.ls_req;
    i_ls_we    = v.ls_we;
    i_ls_addr  = v.ls_addr;
    i_ls_wdata = v.ls_wdata;
    i_ls_bmask = v.ls_bmask;
    @(negedge clk);
    #1;
    e_addr  = v.e_ls_gnt ? v.ls_addr : (v.e_if_gnt ? v.if_addr : 32'd0);
    e_wdata = v.e_ls_gnt ? v.ls_wdata : 32'd0;
    e_bm    = v.e_ls_gnt ? v.ls_bmask : 4'd0;
    chk("if_gnt",    32'(o_if_gnt), 32'(v.e_if_gnt));
    chk("ls_gnt",    32'(o_ls_gnt), 32'(v.e_ls_gnt));
    chk("busy",      32'(o_busy),   32'(v.e_busy));
    chk("mem_en",    32'(o_mem_en), 32'(v.e_if_gnt | v.e_ls_gnt));
    chk("mem_we",    32'(o_mem_we), 32'(v.e_ls_gnt & v.ls_we));
    chk("mem_addr",  o_mem_addr, e_addr);
    chk("mem_wdata", o_mem_wdata, e_wdata);
    chk("mem_bmask", 32'(o_mem_bmask), 32'(e_bm));
    if (track && v.e_if_gnt) sbq.push_back('{1'b0, mem_rd(v.if_addr), cyc + RD_LAT});
    if (track && v.e_ls_gnt && !v.ls_we) sbq.push_back('{1'b1, mem_rd(v.ls_addr), cyc + RD_LAT});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    mem[32'h100] = 32'h0050_0093;
    i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h0;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h2000;
    i_ls_wdata = 32'd0; i_ls_bmask = 4'd0;

    // 0-5: simultaneous IF/LS reads; LS first, IF after LS completes
    tbl.push_back(mk(1, 32'h0,   1, 0, 32'h2000, 0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(1, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h0,   0, 0, 0, 0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    // 6-8: IF fetch of 0x100
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    // 9-15: store passes through, IF granted next cycle, store readback
    tbl.push_back(mk(1, 32'h200, 1, 1, 32'h7000, 32'hDEAD_BEEF, 4'b0011, 0, 1, 0));
    tbl.push_back(mk(1, 32'h200, 0, 0, 0, 0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   1, 0, 32'h7000, 0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    // 16-20: back-to-back stores starve IF for 4 cycles, then IF is forced
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 32'h400, 1, 1, 32'h10 + 32'(i*4), 32'(i + 1), 4'hF, 0, 1, 0));
    tbl.push_back(mk(1, 32'h400, 1, 1, 32'h8000, 32'h1234_5678, 4'b1100, 1, 0, 0));
    // 21-26: held LS store wins once starvation has cleared
    tbl.push_back(mk(0, 32'h0,   1, 1, 32'h8000, 32'h1234_5678, 4'b1100, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   1, 1, 32'h8000, 32'h1234_5678, 4'b1100, 0, 0, 1));
    tbl.push_back(mk(1, 32'h500, 1, 1, 32'h8000, 32'h1234_5678, 4'b1100, 0, 1, 0));
    tbl.push_back(mk(1, 32'h500, 0, 0, 0, 0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    // 27-29: masked-store readback
    tbl.push_back(mk(0, 32'h0,   1, 0, 32'h8000, 0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1));

    // Reset held with both requests pending: nothing may be granted.
    for (int i = 0; i < 3; i++)
      run_row(mk(1, 32'h0, 1, 0, 32'h2000, 0, 4'h0, 0, 0, 0), 1'b1, 1'b0);
    mon_en = 1'b1;

    foreach (tbl[i]) run_row(tbl[i], 1'b0, 1'b1);

    // Reset in the middle of a read: the load is dropped and IF proceeds.
    run_row(mk(0, 32'h0,   1, 0, 32'h2000, 0, 4'h0, 0, 1, 0), 1'b0, 1'b0);
    run_row(mk(1, 32'h300, 0, 0, 0, 0, 4'h0, 0, 0, 0), 1'b1, 1'b0);
    run_row(mk(1, 32'h300, 0, 0, 0, 0, 4'h0, 1, 0, 0), 1'b0, 1'b1);
    chk("ls_rvalid_after_reset", 32'(o_ls_rvalid), 32'd0);
    run_row(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1), 1'b0, 1'b1);
    run_row(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 1), 1'b0, 1'b1);
    run_row(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 0), 1'b0, 1'b1);
    run_row(mk(0, 32'h0,   0, 0, 0, 0, 4'h0, 0, 0, 0), 1'b0, 1'b1);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
